iter_alu: RTL and testbench

- Execution unit that consumes the 3-bit ALU operation code from the ALU control decoder and performs the operation on two operands.
- Single-cycle ops complete in one clock; MULT and DIV are iterative (shift-add / restoring division) and drive a busy/done handshake so the datapath can stall.
- Holds architectural Hi/Lo registers for MULT/DIV results; sits in the EX stage between register-file read and writeback.

---
 rtl/iter_alu.sv | 184 ++++++++++++++++++
 tb/tb_iter_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// EX-stage ALU: single-cycle ADD/SUB/OR/AND/SLT/SLL plus iterative signed MULT
// (shift-add) and DIV (restoring), with Hi/Lo result registers and a busy/done handshake.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       IA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpAnd = 3'b101;
  localparam logic [2:0] OpSlt = 3'b110;
  localparam logic [2:0] OpSll = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;   // product upper half / partial remainder
  logic [WIDTH-1:0] sh_q;    // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] mb_q;    // |B|
  logic             neg_q;   // sign of product / quotient
  logic             rneg_q;  // sign of remainder (dividend sign)
  logic [WIDTH-1:0] res_q, hi_q, lo_q;
  logic             zero_q, busy_q, done_q, dz_q;

  logic [WIDTH-1:0]   mag_a, mag_b, alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_sh;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH:0]     div_rem_sh, div_trial;
  logic [WIDTH-1:0]   div_acc, div_sh, quo, rem;

  always_comb begin
    mag_a = A[WIDTH-1] ? -A : A;
    mag_b = B[WIDTH-1] ? -B : B;
  end

  always_comb begin
    alu_res = '0;
    unique case (IA)
      OpAdd:        alu_res = A + B;
      OpSub:        alu_res = A - B;
      OpOr:         alu_res = A | B;
      OpAnd:        alu_res = A & B;
      OpSlt:        alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OpSll:        alu_res = B << A[4:0];
      OpMul, OpDiv: alu_res = '0;
    endcase
  end

  // One shift-add multiply step on {acc_q, sh_q}
  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mb_q} : '0);
    mul_acc = mul_sum[WIDTH:1];
    mul_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    prod    = {mul_acc, mul_sh};
    prod_s  = neg_q ? -prod : prod;
  end

  // One restoring-division step; trial MSB set means the subtraction went negative
  always_comb begin
    div_rem_sh = {acc_q, sh_q[WIDTH-1]};
    div_trial  = div_rem_sh - {1'b0, mb_q};
    if (!div_trial[WIDTH]) begin
      div_acc = div_trial[WIDTH-1:0];
      div_sh  = {sh_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = div_rem_sh[WIDTH-1:0];
      div_sh  = {sh_q[WIDTH-2:0], 1'b0};
    end
    quo = neg_q ? -div_sh : div_sh;
    rem = rneg_q ? -div_acc : div_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (IA == OpMul || (IA == OpDiv && B != '0)) begin
              state_q <= (IA == OpMul) ? StMul : StDiv;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              acc_q   <= '0;
              sh_q    <= mag_a;
              mb_q    <= mag_b;
              neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
              rneg_q  <= A[WIDTH-1];
            end else if (IA == OpDiv) begin
              lo_q   <= '1;
              hi_q   <= A;
              res_q  <= '1;
              zero_q <= 1'b0;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end else begin
              res_q  <= alu_res;
              zero_q <= (alu_res == '0);
              dz_q   <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        StMul: begin
          if (cnt_q == LastIter) begin
            hi_q    <= prod_s[2*WIDTH-1:WIDTH];
            lo_q    <= prod_s[WIDTH-1:0];
            res_q   <= prod_s[WIDTH-1:0];
            zero_q  <= (prod_s[WIDTH-1:0] == '0);
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= mul_acc;
            sh_q  <= mul_sh;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDiv: begin
          if (cnt_q == LastIter) begin
            hi_q    <= rem;
            lo_q    <= quo;
            res_q   <= quo;
            zero_q  <= (quo == '0);
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= div_acc;
            sh_q  <= div_sh;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Res  = res_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed, table-driven bench for iter_alu with hand-written multi-cycle corner sequences.
module tb_iter_alu;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100, OP_AND = 3'b101, OP_SLT = 3'b110, OP_SLL = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  IA;
  logic [31:0] A, B, Res, Hi, Lo;
  logic        Zero, busy, done, dz;

  int n_chk = 0;
  int n_err = 0;

  iter_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .IA    (IA),
    .A     (A),
    .B     (B),
    .Res   (Res),
    .Hi    (Hi),
    .Lo    (Lo),
    .Zero  (Zero),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bcnt);
    @(negedge clk);
    IA = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; IA = OP_SUB; A = $urandom; B = $urandom;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    logic [31:0] m_hi, m_lo, e_hi, e_lo;
    string tag;

    vecs[0]  = '{OP_ADD, 32'd7, 32'd5, 32'd12, 32'd0, 32'd0, 1'b0, 0};
    vecs[1]  = '{OP_SUB, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 0};
    vecs[2]  = '{OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 0};
    vecs[3]  = '{OP_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b0, 0};
    vecs[4]  = '{OP_SLL, 32'd4, 32'd1, 32'd16, 32'd0, 32'd0, 1'b0, 0};
    vecs[5]  = '{OP_SLL, 32'h3F, 32'd3, 32'h80000000, 32'd0, 32'd0, 1'b0, 0};
    vecs[6]  = '{OP_OR,  32'hF0, 32'h0F, 32'hFF, 32'd0, 32'd0, 1'b0, 0};
    vecs[7]  = '{OP_AND, 32'hF0, 32'h3C, 32'h30, 32'd0, 32'd0, 1'b0, 0};
    vecs[8]  = '{OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 0};
    vecs[9]  = '{OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32};
    vecs[10] = '{OP_ADD, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 0};
    vecs[11] = '{OP_MUL, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 32'd0, 1'b0, 32};
    vecs[12] = '{OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
    vecs[13] = '{OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0, 32};
    vecs[14] = '{OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFD, 1'b0, 32};
    vecs[15] = '{OP_DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 1'b1, 0};
    vecs[16] = '{OP_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b0, 0};
    vecs[17] = '{OP_MUL, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 32};

    reset = 1'b1; start = 1'b0; IA = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset Res", Res, 32'd0);
    chk("reset Hi", Hi, 32'd0);
    chk("reset Lo", Lo, 32'd0);
    chk("reset Zero", {31'd0, Zero}, 32'd1);
    chk("reset busy/done/dz", {29'd0, busy, done, dz}, 32'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, bcnt);
      tag = $sformatf("vec%0d", i);
      if (vecs[i].op == OP_MUL || vecs[i].op == OP_DIV) begin
        m_hi = vecs[i].hi; m_lo = vecs[i].lo;
      end
      e_hi = m_hi; e_lo = m_lo;
      chk({tag, " done latency"}, cyc, vecs[i].lat);
      chk({tag, " busy cycles"}, bcnt, vecs[i].lat);
      chk({tag, " Res"}, Res, vecs[i].res);
      chk({tag, " Zero"}, {31'd0, Zero}, {31'd0, vecs[i].res == 32'd0});
      chk({tag, " Hi"}, Hi, e_hi);
      chk({tag, " Lo"}, Lo, e_lo);
      chk({tag, " dz"}, {31'd0, dz}, {31'd0, vecs[i].dz});
      chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    end

    // start/ADD pulsed mid-MULT must be ignored
    @(negedge clk);
    IA = OP_MUL; A = 32'd6; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    IA = OP_ADD; A = 32'd1; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 5;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ignore latency", cyc, 32);
    chk("ignore Res", Res, 32'd42);
    chk("ignore Hi", Hi, 32'd0);
    chk("ignore Lo", Lo, 32'd42);
    @(negedge clk);
    chk("ignore no queued done", {31'd0, done}, 32'd0);

    // start held through done: ignored on done edge, accepted on the next
    @(negedge clk);
    IA = OP_MUL; A = 32'd2; B = 32'd3; start = 1'b1;
    @(negedge clk);
    IA = OP_ADD; A = 32'd10; B = 32'd20;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("held start mul latency", cyc, 32);
    chk("held start mul Res", Res, 32'd6);
    @(negedge clk);
    start = 1'b0;
    chk("held start add done", {31'd0, done}, 32'd1);
    chk("held start add Res", Res, 32'd30);
    chk("held start add Lo", Lo, 32'd6);
    @(negedge clk);
    chk("held start done drop", {31'd0, done}, 32'd0);

    // reset mid-MULT aborts with no done
    @(negedge clk);
    IA = OP_MUL; A = 32'hFFFFFFFD; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort Res", Res, 32'd0);
    chk("abort Hi", Hi, 32'd0);
    chk("abort Lo", Lo, 32'd0);
    chk("abort Zero", {31'd0, Zero}, 32'd1);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    chk("abort no done/busy", dcnt, 0);
    run_op(OP_ADD, 32'd7, 32'd5, cyc, bcnt);
    chk("post-abort ADD latency", cyc, 0);
    chk("post-abort ADD Res", Res, 32'd12);
    chk("post-abort ADD Hi", Hi, 32'd0);
    chk("post-abort ADD Lo", Lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
